snitch_ptw_arbiter: RTL and testbench

- Shares one `snitch_ptw` page-table walker between `NrPorts` TLB refill requesters, for example the ITLB and DTLB of one or more cores.
- Picks one pending request round-robin, holds it stable toward the PTW for the whole walk, and returns the registered L0 PTE and super-page flag to the winner.
- Sits between the per-core `snitch_l0_tlb`/L1 TLB refill ports and the single PTW instance in the VM subsystem.

---
 rtl/snitch_ptw_arbiter_pkg.sv | 29 ++
 rtl/snitch_ptw_rr_sel.sv | 35 +++
 rtl/snitch_ptw_arbiter.sv | 114 +++++++++++
 tb/tb_snitch_ptw_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_ptw_arbiter_pkg.sv
// Shared types for the PTW arbiter: Sv32 virtual address, default L0 PTE
// layout and the arbiter state encoding.
package snitch_ptw_arbiter_pkg;

  localparam int unsigned PageShift = 12;

  typedef struct packed {
    logic [9:0]  vpn1;
    logic [9:0]  vpn0;
    logic [11:0] page_off;
  } va_t;

  typedef struct packed {
    logic d, a, g, u, x, w, r, v;
  } pte_flags_t;

  typedef struct packed {
    logic [21:0] pa;
    pte_flags_t  flags;
  } l0_pte_dflt_t;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Grant   = 2'd1,
    Walk    = 2'd2,
    Respond = 2'd3
  } ptw_arb_state_e;

endpackage

// File: rtl/snitch_ptw_rr_sel.sv
// Combinational round-robin picker: lowest set request at or after start_i,
// falling back to the lowest set request overall when nothing lies above it.
module snitch_ptw_rr_sel #(
  parameter int unsigned NrPorts  = 2,
  parameter int unsigned IdxWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic [NrPorts-1:0]  req_i,
  input  logic [IdxWidth-1:0] start_i,
  output logic                valid_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic                masked_found;
  logic [IdxWidth-1:0] masked_idx, any_idx;

  // Masked and unmasked scans share one descending loop; the last hit wins.
  always_comb begin
    masked_found = 1'b0;
    masked_idx   = '0;
    any_idx      = '0;
    for (int i = NrPorts - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        any_idx = IdxWidth'(i);
        if (i >= int'(start_i)) begin
          masked_idx   = IdxWidth'(i);
          masked_found = 1'b1;
        end
      end
    end
  end

  assign valid_o = |req_i;
  assign idx_o   = masked_found ? masked_idx : any_idx;

endmodule

// File: rtl/snitch_ptw_arbiter.sv
// Round-robin arbiter sharing one page-table walker between NrPorts TLB refill
// ports. Define SNITCH_PTW_ARB_MERGE_EN to complete matching waiters together.
module snitch_ptw_arbiter
  import snitch_ptw_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts  = 2,
  parameter int unsigned PPNSize  = 32 - PageShift,
  parameter type         l0_pte_t = l0_pte_dflt_t,
  parameter int unsigned IdxWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrPorts-1:0]               req_valid_i,
  output logic [NrPorts-1:0]               req_ready_o,
  input  va_t  [NrPorts-1:0]               req_va_i,
  input  logic [NrPorts-1:0][PPNSize-1:0]  req_ppn_i,
  output l0_pte_t                          rsp_pte_o,
  output logic                             rsp_is_4mega_o,
  output logic                             ptw_valid_o,
  input  logic                             ptw_ready_i,
  output va_t                              ptw_va_o,
  output logic [PPNSize-1:0]               ptw_ppn_o,
  input  l0_pte_t                          ptw_pte_i,
  input  logic                             ptw_is_4mega_i
);

  ptw_arb_state_e      state_q, state_d;
  logic [IdxWidth-1:0] rr_q, grant_q, sel_idx;
  logic                sel_valid;
  va_t                 va_q;
  logic [PPNSize-1:0]  ppn_q;
  l0_pte_t             pte_q;
  logic                mega_q, valid_q;

  snitch_ptw_rr_sel #(
    .NrPorts  (NrPorts),
    .IdxWidth (IdxWidth)
  ) i_rr_sel (
    .req_i   (req_valid_i),
    .start_i (rr_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:    if (sel_valid) state_d = Grant;
      Grant:   state_d = Walk;
      Walk:    if (ptw_ready_i) state_d = Respond;
      Respond: state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= Idle;
      rr_q    <= '0;
      grant_q <= '0;
      va_q    <= '0;
      ppn_q   <= '0;
      pte_q   <= '0;
      mega_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        Idle: if (sel_valid) begin
          grant_q <= sel_idx;
          va_q    <= req_va_i[sel_idx];
          ppn_q   <= req_ppn_i[sel_idx];
        end
        Grant: valid_q <= 1'b1;
        // Completions outside Walk are dropped: a late PTW answer after reset.
        Walk: if (ptw_ready_i) begin
          valid_q <= 1'b0;
          pte_q   <= ptw_pte_i;
          mega_q  <= ptw_is_4mega_i;
        end
        Respond: rr_q <= (grant_q == IdxWidth'(NrPorts - 1)) ? '0 : grant_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == Respond) begin
      req_ready_o[grant_q] = 1'b1;
`ifdef SNITCH_PTW_ARB_MERGE_EN
      // Same root and same translation (or same super-page) share the answer.
      for (int j = 0; j < NrPorts; j++) begin
        if (req_valid_i[j] && req_ppn_i[j] == ppn_q &&
            req_va_i[j].vpn1 == va_q.vpn1 &&
            (mega_q || req_va_i[j].vpn0 == va_q.vpn0))
          req_ready_o[j] = 1'b1;
      end
`endif
    end
  end

  assign ptw_valid_o    = valid_q;
  assign ptw_va_o       = va_q;
  assign ptw_ppn_o      = ppn_q;
  assign rsp_pte_o      = pte_q;
  assign rsp_is_4mega_o = mega_q;

  a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != Idle) |-> req_valid_i[grant_q]);
  a_ready_in_walk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ptw_ready_i |-> (state_q == Walk));

endmodule

// File: tb/tb_snitch_ptw_arbiter.sv
// Self-checking bench for snitch_ptw_arbiter; honours SNITCH_PTW_ARB_MERGE_EN.
module tb_snitch_ptw_arbiter;
  import snitch_ptw_arbiter_pkg::*;

  localparam int NP = 2;
  localparam int PW = 32 - PageShift;
`ifdef SNITCH_PTW_ARB_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NP-1:0]         req_valid, req_ready;
  va_t  [NP-1:0]         req_va;
  logic [NP-1:0][PW-1:0] req_ppn;
  l0_pte_dflt_t          rsp_pte, ptw_pte;
  logic                  rsp_mega, ptw_valid, ptw_ready, ptw_mega;
  va_t                   ptw_va;
  logic [PW-1:0]         ptw_ppn;

  always #5 clk = ~clk;

  snitch_ptw_arbiter #(.NrPorts(NP), .PPNSize(PW), .l0_pte_t(l0_pte_dflt_t)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_va_i(req_va), .req_ppn_i(req_ppn), .rsp_pte_o(rsp_pte), .rsp_is_4mega_o(rsp_mega),
    .ptw_valid_o(ptw_valid), .ptw_ready_i(ptw_ready), .ptw_va_o(ptw_va), .ptw_ppn_o(ptw_ppn),
    .ptw_pte_i(ptw_pte), .ptw_is_4mega_i(ptw_mega));

  int errors = 0;
  int checks = 0;
  int rr_m   = 0;

  // Reference: first pending port at or after the round-robin pointer.
  function automatic int pick(logic [NP-1:0] pend, int start);
    for (int k = 0; k < NP; k++)
      if (pend[(start + k) % NP]) return (start + k) % NP;
    return 0;
  endfunction

  function automatic logic [NP-1:0] exp_ready(int w, logic [NP-1:0] pend, logic mega);
    logic [NP-1:0] m, hit;
    m = '0;
    m[w] = 1'b1;
    for (int j = 0; j < NP; j++)
      hit[j] = pend[j] && req_ppn[j] == req_ppn[w] && req_va[j].vpn1 == req_va[w].vpn1 &&
               (mega || req_va[j].vpn0 == req_va[w].vpn0);
    if (MERGE) m |= hit;
    return m;
  endfunction

  // PTW model: waits for a walk, answers after dly cycles, returns what was seen.
  task automatic serve(input int dly, input l0_pte_dflt_t pte, input logic mega,
                       output bit tmo, output va_t gva, output logic [PW-1:0] gppn,
                       output logic [NP-1:0] grdy, output l0_pte_dflt_t gpte,
                       output logic gmega);
    int n = 0;
    tmo = 1'b0; gva = '0; gppn = '0; grdy = '0; gpte = '0; gmega = 1'b0;
    @(negedge clk);
    while (!ptw_valid) begin
      n++;
      if (n > 30) begin tmo = 1'b1; return; end
      @(negedge clk);
    end
    gva = ptw_va; gppn = ptw_ppn;
    repeat (dly) @(negedge clk);
    ptw_ready = 1'b1; ptw_pte = pte; ptw_mega = mega;
    @(posedge clk); #1;
    ptw_ready = 1'b0; ptw_pte = l0_pte_dflt_t'($urandom); ptw_mega = 1'b0;
    @(negedge clk);
    grdy = req_ready; gpte = rsp_pte; gmega = rsp_mega;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0; req_va = '0; req_ppn = '0;
    ptw_ready = 1'b0; ptw_pte = '0; ptw_mega = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; rr_m = 0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (ptw_valid !== 1'b0) begin errors++; $display("FAIL reset_ptw_valid: got %b want 0", ptw_valid); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    checks++; if (rsp_pte !== '0) begin errors++; $display("FAIL reset_rsp_pte: got %h want 0", rsp_pte); end
    checks++; if (rsp_mega !== 1'b0) begin errors++; $display("FAIL reset_rsp_mega: got %b want 0", rsp_mega); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    l0_pte_dflt_t p;
    p = '0; p.pa = 22'h1234; p.flags.a = 1'b1; p.flags.v = 1'b1; p.flags.r = 1'b1;
    req_va[0] = va_t'(32'h0040_3000); req_ppn[0] = PW'(32'h100); req_valid = 2'b01;
    @(negedge clk);
    checks++; if (ptw_valid !== 1'b0) begin errors++; $display("FAIL single_c0_valid: got %b want 0", ptw_valid); end
    @(negedge clk);
    checks++; if (ptw_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid: got %b want 0", ptw_valid); end
    @(negedge clk);
    checks++; if (ptw_valid !== 1'b1) begin errors++; $display("FAIL single_c2_valid: got %b want 1", ptw_valid); end
    checks++; if (ptw_va !== va_t'(32'h0040_3000) || ptw_ppn !== PW'(32'h100))
      begin errors++; $display("FAIL single_addr: got va %h ppn %h want 00403000 100", ptw_va, ptw_ppn); end
    repeat (4) @(negedge clk);
    checks++; if (ptw_valid !== 1'b1 || req_ready !== '0)
      begin errors++; $display("FAIL single_walk_hold: got valid %b ready %b want 1 00", ptw_valid, req_ready); end
    @(negedge clk);
    ptw_ready = 1'b1; ptw_pte = p; ptw_mega = 1'b0;
    @(posedge clk); #1;
    ptw_ready = 1'b0; ptw_pte = '0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    checks++; if (rsp_pte !== p || rsp_mega !== 1'b0)
      begin errors++; $display("FAIL single_rsp: got %h/%b want %h/0", rsp_pte, rsp_mega, p); end
    checks++; if (ptw_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", ptw_valid); end
    @(posedge clk); #1;
    req_valid = '0; rr_m = 1;
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL single_ready_pulse: got %b want 00", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous;
    int w; logic [NP-1:0] em; bit tmo; va_t gva; logic [PW-1:0] gppn;
    logic [NP-1:0] grdy; l0_pte_dflt_t gpte, p; logic gmega;
    do_reset();
    req_va[0] = va_t'(32'h0040_3000); req_ppn[0] = PW'(32'h100);
    req_va[1] = va_t'(32'h0080_5000); req_ppn[1] = PW'(32'h100);
    req_valid = 2'b11;
    // Two rounds: the second confirms the pointer wrapped back to port 0.
    for (int it = 0; it < 4; it++) begin
      if (it == 2) req_valid = 2'b11;
      w = pick(req_valid, rr_m); em = exp_ready(w, req_valid, 1'b0);
      p = l0_pte_dflt_t'($urandom);
      serve(1, p, 1'b0, tmo, gva, gppn, grdy, gpte, gmega);
      checks++; if (tmo) begin errors++; $display("FAIL simul_timeout: no ptw_valid on walk %0d", it); return; end
      checks++; if (gva !== req_va[w]) begin errors++; $display("FAIL simul_order: walk %0d got va %h want %h", it, gva, req_va[w]); end
      checks++; if (grdy !== em) begin errors++; $display("FAIL simul_ready: walk %0d got %b want %b", it, grdy, em); end
      checks++; if (gpte !== p) begin errors++; $display("FAIL simul_rsp: got %h want %h", gpte, p); end
      req_valid &= ~em; rr_m = (w + 1) % NP;
      if (req_valid == '0 && it == 1 && MERGE) it = 3;
    end
  endtask

  task automatic test_fairness;
    int w; logic [NP-1:0] em; bit tmo; va_t gva; logic [PW-1:0] gppn;
    logic [NP-1:0] grdy; l0_pte_dflt_t gpte, p; logic gmega;
    req_va[0] = va_t'(32'h0040_3000); req_ppn[0] = PW'(32'h200);
    req_va[1] = va_t'(32'h00C0_1000); req_ppn[1] = PW'(32'h200);
    req_valid = 2'b11;
    for (int it = 0; it < 3; it++) begin
      w = pick(req_valid, rr_m); em = exp_ready(w, req_valid, 1'b0);
      p = l0_pte_dflt_t'($urandom);
      serve(it, p, 1'b0, tmo, gva, gppn, grdy, gpte, gmega);
      checks++; if (tmo) begin errors++; $display("FAIL fair_timeout: no ptw_valid on walk %0d", it); return; end
      checks++; if (gva !== req_va[w] || gppn !== req_ppn[w])
        begin errors++; $display("FAIL fair_grant: walk %0d got va %h want %h", it, gva, req_va[w]); end
      checks++; if (grdy !== em) begin errors++; $display("FAIL fair_ready: walk %0d got %b want %b", it, grdy, em); end
      req_valid &= ~em; rr_m = (w + 1) % NP;
      // Port 0 comes straight back after its first walk.
      if (it == 0) begin req_va[0] = va_t'(32'h0100_2000); req_valid[0] = 1'b1; end
      if (req_valid == '0) break;
    end
    req_valid = '0;
  endtask

  task automatic test_merge;
    int w, walks; logic [NP-1:0] em; bit tmo; va_t gva; logic [PW-1:0] gppn;
    logic [NP-1:0] grdy; l0_pte_dflt_t gpte, p; logic gmega, mg, seen;
    for (int c = 0; c < 3; c++) begin
      req_va[0] = va_t'(32'h0040_3000); req_ppn[0] = PW'(32'h100);
      req_va[1] = (c == 0) ? va_t'(32'h0040_3000) : va_t'(32'h0040_7000); req_ppn[1] = PW'(32'h100);
      mg = (c == 1);
      req_valid = 2'b11; walks = 0;
      while (req_valid != '0 && walks < NP + 1) begin
        w = pick(req_valid, rr_m); em = exp_ready(w, req_valid, mg);
        p = l0_pte_dflt_t'($urandom);
        serve(2, p, mg, tmo, gva, gppn, grdy, gpte, gmega);
        walks++;
        checks++; if (tmo) begin errors++; $display("FAIL merge_timeout: case %0d", c); return; end
        checks++; if (gva !== req_va[w]) begin errors++; $display("FAIL merge_grant: case %0d got va %h want %h", c, gva, req_va[w]); end
        checks++; if (grdy !== em) begin errors++; $display("FAIL merge_ready: case %0d got %b want %b", c, grdy, em); end
        checks++; if (gpte !== p || gmega !== mg)
          begin errors++; $display("FAIL merge_rsp: case %0d got %h/%b want %h/%b", c, gpte, gmega, p, mg); end
        req_valid &= ~em; rr_m = (w + 1) % NP;
      end
      seen = 1'b0;
      repeat (6) begin @(negedge clk); seen |= ptw_valid; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL merge_extra_walk: case %0d got walk want none", c); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_walk;
    int n = 0; logic seen;
    req_va[0] = va_t'(32'h0040_3000); req_ppn[0] = PW'(32'h100); req_valid = 2'b01;
    @(negedge clk);
    while (!ptw_valid && n < 30) begin n++; @(negedge clk); end
    checks++; if (ptw_valid !== 1'b1) begin errors++; $display("FAIL rstwalk_timeout: got valid %b want 1", ptw_valid); return; end
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0;
    ptw_ready = 1'b1; ptw_pte = l0_pte_dflt_t'(30'h3ABC_DEF1); ptw_mega = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; ptw_ready = 1'b0; ptw_mega = 1'b0; rr_m = 0;
    @(negedge clk);
    checks++; if (ptw_valid !== 1'b0) begin errors++; $display("FAIL rstwalk_valid: got %b want 0", ptw_valid); end
    checks++; if (req_ready !== '0 || rsp_pte !== '0 || rsp_mega !== 1'b0)
      begin errors++; $display("FAIL rstwalk_outputs: got rdy %b pte %h mega %b want 0", req_ready, rsp_pte, rsp_mega); end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= (|req_ready) | ptw_valid; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstwalk_late: got activity want none"); end
    @(posedge clk); #1;
  endtask

  task automatic test_fault;
    int w; logic [NP-1:0] em; bit tmo; va_t gva; logic [PW-1:0] gppn;
    logic [NP-1:0] grdy; l0_pte_dflt_t gpte, p; logic gmega, mg;
    req_va[1] = va_t'($urandom); req_ppn[1] = PW'($urandom); req_valid = 2'b10;
    p = l0_pte_dflt_t'($urandom); p.flags.a = 1'b0; mg = 1'($urandom);
    w = pick(req_valid, rr_m); em = exp_ready(w, req_valid, mg);
    serve(3, p, mg, tmo, gva, gppn, grdy, gpte, gmega);
    checks++; if (tmo) begin errors++; $display("FAIL fault_timeout: no ptw_valid"); return; end
    checks++; if (grdy !== em) begin errors++; $display("FAIL fault_ready: got %b want %b", grdy, em); end
    checks++; if (gpte !== p || gmega !== mg)
      begin errors++; $display("FAIL fault_rsp: got %h/%b want %h/%b", gpte, gmega, p, mg); end
    req_valid &= ~em; rr_m = (w + 1) % NP;
  endtask

  task automatic test_random;
    int w; logic [NP-1:0] em; bit tmo; va_t gva; logic [PW-1:0] gppn;
    logic [NP-1:0] grdy; l0_pte_dflt_t gpte, p; logic gmega, mg;
    logic [31:0] vas [4];
    vas[0] = 32'h0040_3000; vas[1] = 32'h0040_7000; vas[2] = 32'h0080_3000; vas[3] = $urandom;
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < NP; j++)
        if (!req_valid[j] && $urandom_range(0, 1) == 1) begin
          req_va[j]  = va_t'(vas[$urandom_range(0, 3)]);
          req_ppn[j] = PW'(32'h100 + $urandom_range(0, 1));
          req_valid[j] = 1'b1;
        end
      if (req_valid == '0) begin
        req_va[0] = va_t'($urandom); req_ppn[0] = PW'(32'h100); req_valid[0] = 1'b1;
      end
      mg = 1'($urandom); p = l0_pte_dflt_t'($urandom);
      w = pick(req_valid, rr_m); em = exp_ready(w, req_valid, mg);
      serve($urandom_range(0, 3), p, mg, tmo, gva, gppn, grdy, gpte, gmega);
      checks++; if (tmo) begin errors++; $display("FAIL rand_timeout: iteration %0d", it); return; end
      checks++; if (gva !== req_va[w] || gppn !== req_ppn[w])
        begin errors++; $display("FAIL rand_grant: it %0d got %h/%h want %h/%h", it, gva, gppn, req_va[w], req_ppn[w]); end
      checks++; if (grdy !== em) begin errors++; $display("FAIL rand_ready: it %0d got %b want %b", it, grdy, em); end
      checks++; if (gpte !== p || gmega !== mg)
        begin errors++; $display("FAIL rand_rsp: it %0d got %h/%b want %h/%b", it, gpte, gmega, p, mg); end
      req_valid &= ~em; rr_m = (w + 1) % NP;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_merge();
    test_reset_mid_walk();
    test_fault();
    test_random();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
